// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg
// Shared types and default parameter values for the FIFO-to-stream reader.
// Contents:
//   state_t           - controller state encoding (IDLE, RUN)
//   DEF_WIDTH         - default data word width
//   DEF_LEN_WIDTH     - default burst-length field width
//   DEF_TIMEOUT       - default starvation limit in cycles
package fifo_stream_reader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_LEN_WIDTH = 8;
  localparam int DEF_TIMEOUT   = 255;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
// Registered valid/ready stream carrying the words drained from the FIFO.
// Signals:
//   m_valid_o  master -> slave  word present
//   m_ready_i  slave  -> master consumer accepts the word
//   m_data_o   master -> slave  data word (WIDTH bits)
//   m_last_o   master -> slave  final word of a burst, qualified by m_valid_o
// Modports: master (the reader), slave (the consumer).
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             m_valid_o;
  logic             m_ready_i;
  logic [WIDTH-1:0] m_data_o;
  logic             m_last_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a first-word-fall-through FIFO read port into a registered
// valid/ready stream, one burst of len_i words per start command. The final
// word carries m_last_o and done_o pulses once it has been accepted.
//
// Ports:
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset
//   start_i, len_i  burst command, sampled only in IDLE
//   busy_o          high while a burst is running
//   done_o          one-cycle completion pulse
//   err_o           one-cycle starvation-timeout pulse
//   fifo_rd_en_o    FIFO pop (combinational)
//   fifo_rd_data_i  FIFO head word
//   fifo_empty_i    FIFO empty flag
//   m_if            output stream (master modport)
//
// Optional feature: define FIFO_STREAM_READER_TIMEOUT_EN to abandon a burst
// after TIMEOUT starved cycles. Without it err_o is tied low and a burst
// waits on the FIFO indefinitely.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i; output register empty
// RUN   | popping words until rem reaches 0 and the last word drains
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 fifo_rd_en_o,
  input  logic [WIDTH-1:0]     fifo_rd_data_i,
  input  logic                 fifo_empty_i,
  fifo_stream_reader_if.master m_if
);

  state_t               state_q;
  state_t               state_d;
  logic [LEN_WIDTH-1:0] rem_q;
  logic                 done_q;
  logic                 m_valid_q;
  logic                 m_last_q;
  logic [WIDTH-1:0]     m_data_q;

  logic pop;
  logic hs;
  logic last_hs;
  logic abort;

  // Pop only when the output register is free or being emptied this cycle;
  // never while the FIFO reports empty.
  assign pop = (state_q == RUN) && (rem_q != '0) && !fifo_empty_i &&
               (!m_valid_q || m_if.m_ready_i);
  assign hs      = m_valid_q && m_if.m_ready_i;
  assign last_hs = hs && m_last_q;

`ifdef FIFO_STREAM_READER_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT-1; the abort fires on the cycle
  // that would make it TIMEOUT.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] starve_q;
  logic             starve;
  logic             err_q;

  // A word sitting in the output register is the consumer's problem, not
  // starvation, so m_valid_q blocks the count.
  assign starve = (state_q == RUN) && (rem_q != '0) && fifo_empty_i && !m_valid_q;
  assign abort  = starve && (starve_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= abort;
      if ((state_q != RUN) || pop || abort) begin
        starve_q <= '0;
      end else if (starve) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i && (len_i != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_hs || abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o       = (state_q == RUN);
    done_o       = done_q;
    fifo_rd_en_o = pop;
  end

  assign m_if.m_valid_o = m_valid_q;
  assign m_if.m_data_o  = m_data_q;
  assign m_if.m_last_o  = m_last_q;

  // Remaining-word counter, completion pulse and output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q     <= '0;
      done_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      done_q <= ((state_q == IDLE) && start_i && (len_i == '0)) || last_hs || abort;

      if ((state_q == IDLE) && start_i) begin
        rem_q <= len_i;
      end else if (abort) begin
        rem_q <= '0;
      end else if (pop) begin
        rem_q <= rem_q - 1'b1;
      end

      if (pop) begin
        m_valid_q <= 1'b1;
        m_data_q  <= fifo_rd_data_i;
        m_last_q  <= (rem_q == LEN_WIDTH'(1));
      end else if (hs) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] len_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic       fifo_rd_en_o;
  logic [7:0] fifo_rd_data_i;
  logic       fifo_empty_i;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  fifo_stream_reader_if #(.WIDTH(8)) m_if ();

  fifo_stream_reader #(
    .WIDTH     (8),
    .LEN_WIDTH (8),
    .TIMEOUT   (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .len_i          (len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_empty_i   (fifo_empty_i),
    .m_if           (m_if)
  );

  // FWFT FIFO model
  logic [7:0] fifo_mem [0:511];
  int         wr_ptr   = 0;
  int         rd_ptr   = 0;
  int         pops     = 0;
  int         bad_pops = 0;
  logic       flush    = 1'b0;
  logic [8:0] rd_idx;

  assign rd_idx         = rd_ptr[8:0];
  assign fifo_empty_i   = (wr_ptr == rd_ptr);
  assign fifo_rd_data_i = fifo_mem[rd_idx];

  always @(posedge clk_i) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en_o) begin
      if (fifo_empty_i) bad_pops <= bad_pops + 1;
      else begin
        rd_ptr <= rd_ptr + 1;
        pops   <= pops + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic push(input logic [7:0] d);
    logic [8:0] idx;
    idx = wr_ptr[8:0];
    fifo_mem[idx] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy_o, done_o, err_o, m_if.m_valid_o, m_if.m_last_o, fifo_rd_en_o, m_if.m_data_o} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b valid=%b last=%b rd_en=%b data=%h, want all 0",
               busy_o, done_o, err_o, m_if.m_valid_o, m_if.m_last_o, fifo_rd_en_o, m_if.m_data_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int p0;
    do_flush();
    for (int i = 0; i < 4; i++) push(8'(16 + i));
    m_if.m_ready_i = 1'b1;
    p0 = pops;
    start_i = 1'b1; len_i = 8'd4;
    tick();
    start_i = 1'b0;
    vectors++;
    if ({busy_o, m_if.m_valid_o, fifo_rd_en_o} !== 3'b101) begin
      miscompares++;
      $display("FAIL basic_cycle1: got busy/valid/rd_en=%b, want 101", {busy_o, m_if.m_valid_o, fifo_rd_en_o});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({m_if.m_valid_o, m_if.m_data_o, m_if.m_last_o} !== {1'b1, 8'(16 + i), (i == 3)}) begin
        miscompares++;
        $display("FAIL basic_word%0d: got valid=%b data=%h last=%b, want 1 %h %b",
                 i, m_if.m_valid_o, m_if.m_data_o, m_if.m_last_o, 8'(16 + i), (i == 3));
      end
    end
    tick();
    vectors++;
    if ({done_o, busy_o, m_if.m_valid_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL basic_done: got done/busy/valid=%b, want 100", {done_o, busy_o, m_if.m_valid_o});
    end
    vectors++;
    if (pops - p0 !== 4) begin
      miscompares++;
      $display("FAIL basic_pops: got %0d, want 4", pops - p0);
    end
    tick();
    vectors++;
    if (done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse: got done=%b one cycle later, want 0", done_o);
    end
  endtask

  task automatic test_backpressure();
    int         p0;
    int         got      = 0;
    int         hold_bad = 0;
    bit         done_seen = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev = '0;
    logic [3:0] pat = 4'b1001;
    do_flush();
    for (int i = 0; i < 4; i++) push(8'(32 + i));
    p0 = pops;
    m_if.m_ready_i = 1'b1;
    start_i = 1'b1; len_i = 8'd4;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (done_o) done_seen = 1;
      if (prev_stall && ({m_if.m_valid_o, m_if.m_last_o, m_if.m_data_o} !== prev)) hold_bad++;
      m_if.m_ready_i = pat[c % 4];
      if (m_if.m_valid_o && m_if.m_ready_i) begin
        vectors++;
        if ({m_if.m_data_o, m_if.m_last_o} !== {8'(32 + got), (got == 3)}) begin
          miscompares++;
          $display("FAIL bp_word%0d: got data=%h last=%b, want %h %b",
                   got, m_if.m_data_o, m_if.m_last_o, 8'(32 + got), (got == 3));
        end
        got++;
      end
      prev_stall = m_if.m_valid_o && !m_if.m_ready_i;
      prev = {m_if.m_valid_o, m_if.m_last_o, m_if.m_data_o};
      tick();
    end
    m_if.m_ready_i = 1'b1;
    vectors++;
    if (!done_seen || got != 4 || hold_bad != 0) begin
      miscompares++;
      $display("FAIL bp_summary: got done=%0d words=%0d hold_violations=%0d, want 1 4 0", done_seen, got, hold_bad);
    end
    vectors++;
    if (pops - p0 !== 4) begin
      miscompares++;
      $display("FAIL bp_pops: got %0d, want 4", pops - p0);
    end
  endtask

  task automatic test_starved();
    int p0, b0;
    int got = 0, pushed = 0, done_cyc = -1, hs_cyc = -2;
    do_flush();
    p0 = pops; b0 = bad_pops;
    m_if.m_ready_i = 1'b1;
    start_i = 1'b1; len_i = 8'd3;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 60 && done_cyc < 0; c++) begin
      if (done_o) done_cyc = c;
      if (m_if.m_valid_o) begin
        vectors++;
        if ({m_if.m_data_o, m_if.m_last_o} !== {8'(48 + got), (got == 2)}) begin
          miscompares++;
          $display("FAIL starve_word%0d: got data=%h last=%b, want %h %b",
                   got, m_if.m_data_o, m_if.m_last_o, 8'(48 + got), (got == 2));
        end
        got++;
        hs_cyc = c;
      end
      if ((c % 3 == 2) && pushed < 3) begin
        push(8'(48 + pushed));
        pushed++;
      end
      tick();
    end
    vectors++;
    if (got != 3 || done_cyc != hs_cyc + 1) begin
      miscompares++;
      $display("FAIL starve_done: got words=%0d done_cycle=%0d last_hs_cycle=%0d, want 3 and done one after", got, done_cyc, hs_cyc);
    end
    vectors++;
    if ((bad_pops - b0 !== 0) || (pops - p0 !== 3)) begin
      miscompares++;
      $display("FAIL starve_pops: got pops_on_empty=%0d pops=%0d, want 0 3", bad_pops - b0, pops - p0);
    end
  endtask

  task automatic test_boundary();
    int  p0;
    int  got = 0;
    int  vseen = 0;
    bit  done_seen = 0;
    do_flush();
    push(8'hAA);
    p0 = pops;
    m_if.m_ready_i = 1'b1;
    start_i = 1'b1; len_i = 8'd0;
    tick();
    start_i = 1'b0;
    vectors++;
    if ({done_o, busy_o, m_if.m_valid_o, fifo_rd_en_o} !== 4'b1000) begin
      miscompares++;
      $display("FAIL len0_done: got done/busy/valid/rd_en=%b, want 1000", {done_o, busy_o, m_if.m_valid_o, fifo_rd_en_o});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (m_if.m_valid_o || done_o) vseen++;
    end
    vectors++;
    if (vseen != 0 || pops - p0 != 0 || wr_ptr - rd_ptr != 1) begin
      miscompares++;
      $display("FAIL len0_quiet: got valid/done_cycles=%0d pops=%0d occupancy=%0d, want 0 0 1", vseen, pops - p0, wr_ptr - rd_ptr);
    end

    for (int k = 1; k < 300; k++) push(8'(k));
    start_i = 1'b1; len_i = 8'd255;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      if (done_o) done_seen = 1;
      if (c == 10) begin start_i = 1'b1; len_i = 8'd5; end
      if (c == 11) start_i = 1'b0;
      if (m_if.m_valid_o) begin
        vectors++;
        if ({m_if.m_data_o, m_if.m_last_o} !== {((got == 0) ? 8'hAA : 8'(got)), (got == 254)}) begin
          miscompares++;
          $display("FAIL len255_word%0d: got data=%h last=%b, want %h %b",
                   got, m_if.m_data_o, m_if.m_last_o, ((got == 0) ? 8'hAA : 8'(got)), (got == 254));
        end
        got++;
      end
      tick();
    end
    vectors++;
    if (!done_seen || got != 255 || wr_ptr - rd_ptr != 45) begin
      miscompares++;
      $display("FAIL len255_count: got done=%0d words=%0d remaining=%0d, want 1 255 45", done_seen, got, wr_ptr - rd_ptr);
    end
    tick();
    tick();
    vectors++;
    if ({busy_o, m_if.m_valid_o} !== 2'b00 || wr_ptr - rd_ptr != 45) begin
      miscompares++;
      $display("FAIL start_in_run: got busy=%b valid=%b remaining=%0d, want 0 0 45", busy_o, m_if.m_valid_o, wr_ptr - rd_ptr);
    end
  endtask

  task automatic test_reset_mid();
    do_flush();
    for (int i = 0; i < 4; i++) push(8'(64 + i));
    m_if.m_ready_i = 1'b0;
    start_i = 1'b1; len_i = 8'd4;
    tick();
    start_i = 1'b0;
    tick();
    vectors++;
    if ({m_if.m_valid_o, m_if.m_data_o} !== {1'b1, 8'h40}) begin
      miscompares++;
      $display("FAIL rst_pre: got valid=%b data=%h, want 1 40", m_if.m_valid_o, m_if.m_data_o);
    end
    rst_i = 1'b1;
    tick();
    vectors++;
    if ({busy_o, done_o, err_o, m_if.m_valid_o, m_if.m_last_o, fifo_rd_en_o, m_if.m_data_o} !== 14'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b err=%b valid=%b last=%b rd_en=%b data=%h, want all 0",
               busy_o, done_o, err_o, m_if.m_valid_o, m_if.m_last_o, fifo_rd_en_o, m_if.m_data_o);
    end
    rst_i = 1'b0;
    do_flush();
    push(8'h50);
    push(8'h51);
    m_if.m_ready_i = 1'b1;
    start_i = 1'b1; len_i = 8'd2;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({m_if.m_valid_o, m_if.m_data_o, m_if.m_last_o} !== {1'b1, 8'(80 + i), (i == 1)}) begin
        miscompares++;
        $display("FAIL rst_after_word%0d: got valid=%b data=%h last=%b, want 1 %h %b",
                 i, m_if.m_valid_o, m_if.m_data_o, m_if.m_last_o, 8'(80 + i), (i == 1));
      end
    end
    tick();
    vectors++;
    if ({done_o, busy_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_after_done: got done/busy=%b, want 10", {done_o, busy_o});
    end
  endtask

`ifdef FIFO_STREAM_READER_TIMEOUT_EN
  task automatic test_timeout();
    bit last_seen = 0;
    do_flush();
    push(8'h60);
    m_if.m_ready_i = 1'b1;
    start_i = 1'b1; len_i = 8'd2;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (m_if.m_last_o) last_seen = 1;
      if (c == 2) begin
        vectors++;
        if ({m_if.m_valid_o, m_if.m_data_o} !== {1'b1, 8'h60}) begin
          miscompares++;
          $display("FAIL to_word: got valid=%b data=%h, want 1 60", m_if.m_valid_o, m_if.m_data_o);
        end
      end
      if (c == 6) begin
        vectors++;
        if ({err_o, done_o, busy_o} !== 3'b001) begin
          miscompares++;
          $display("FAIL to_early: got err/done/busy=%b in cycle 6, want 001", {err_o, done_o, busy_o});
        end
      end
      if (c == 7) begin
        vectors++;
        if ({err_o, done_o, busy_o} !== 3'b110) begin
          miscompares++;
          $display("FAIL to_fire: got err/done/busy=%b in cycle 7, want 110", {err_o, done_o, busy_o});
        end
      end
      tick();
    end
    vectors++;
    if (last_seen || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL to_after: got last_seen=%0d err=%b, want 0 0", last_seen, err_o);
    end
  endtask
`endif

  initial begin
    rst_i          = 1'b1;
    start_i        = 1'b0;
    len_i          = 8'd0;
    m_if.m_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_starved();
    test_boundary();
    test_reset_mid();
`ifdef FIFO_STREAM_READER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drains the read port of a first-word-fall-through FIFO (`rd_en`/`rd_data`/`empty` style) into a registered valid/ready stream, one burst at a time. A controller issues a start command with a word count. The block pops exactly that many words, marks the final word with `m_last_o`, and pulses `done_o` when the final word has been accepted downstream. It sits between the FIFO and any stream consumer, such as a DMA or serializer, and sustains one word per cycle.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO.
- `LEN_WIDTH`, 8, width of the burst length; maximum burst is 2^LEN_WIDTH-1 words.
- `TIMEOUT`, 255, starvation limit in cycles; used only with the timeout macro.
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  start a burst; sampled only in IDLE.
- `len_i`  in  LEN_WIDTH  word count for the burst; sampled together with `start_i`.
- `busy_o`  out  1  high while in RUN.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  one-cycle timeout pulse; tied 0 without the macro.
- `fifo_rd_en_o`  out  1  FIFO pop; combinational.
- `fifo_rd_data_i`  in  WIDTH  FIFO head word; valid when `fifo_empty_i`=0.
- `fifo_empty_i`  in  1  FIFO empty flag.
- `m_valid_o`  out  1  stream valid; registered.
- `m_ready_i`  in  1  stream ready.
- `m_data_o`  out  WIDTH  stream data; registered.
- `m_last_o`  out  1  final word of the burst; registered, qualified by `m_valid_o`.

## Operation
- **States:** IDLE and RUN. A remaining-word counter `rem` is LEN_WIDTH bits wide.
- **IDLE:**
  - `start_i`=1 and `len_i`≠0: `rem`←`len_i`, go to RUN.
  - `start_i`=1 and `len_i`=0: stay in IDLE; `done_o`=1 in the next cycle; no words are moved.
- **RUN:**
  - `start_i` is ignored.
  - Pop condition: `fifo_rd_en_o` = RUN & (`rem`≠0) & ~`fifo_empty_i` & (~`m_valid_o` | `m_ready_i`).
  - On a pop: `m_data_o`←`fifo_rd_data_i`, `m_valid_o`←1, `m_last_o`←(`rem`==1), `rem`←`rem`-1.
  - On a handshake without a pop: `m_valid_o`←0.
- **Empty gating:** the block never pops while `fifo_empty_i`=1. It does not rely on the FIFO's write-to-read bypass.
- **Exit:** a handshake (`m_valid_o`&`m_ready_i`) with `m_last_o`=1 moves the block to IDLE and sets `done_o`=1 in the next cycle.
- **Backpressure:** `m_data_o`, `m_valid_o` and `m_last_o` hold stable while `m_valid_o`=1 and `m_ready_i`=0. No pop occurs during that time.
- **Reset:** reset in any state returns the block to IDLE and clears `rem`. All outputs go to 0: `busy_o`, `done_o`, `err_o`, `m_valid_o`, `m_last_o`, and `m_data_o`=0. Any word held in the output register is discarded.

## Timing
- `start_i` sampled at edge 0 → RUN from cycle 1. `busy_o` is registered from the state and reads 1 in cycle 1.
- First pop is possible in cycle 1; `m_valid_o`=1 in cycle 2. FIFO-head-to-stream latency is 1 cycle.
- Sustained throughput is 1 word/cycle when the FIFO is non-empty and `m_ready_i`=1.
- Final handshake in cycle N → `done_o`=1 and `busy_o`=0 in cycle N+1. A new `start_i` is accepted in cycle N+1, so bursts can run back-to-back with a single idle cycle between them.
- `fifo_rd_en_o` is combinational from the state, `rem`, `fifo_empty_i`, `m_valid_o` and `m_ready_i`. There is no combinational path from `fifo_rd_data_i` to any output.

## Configuration
- Macro: `FIFO_STREAM_READER_TIMEOUT_EN`.
- **Defined:** a starvation counter runs in RUN.
  - It increments each cycle with `rem`≠0, `fifo_empty_i`=1 and `m_valid_o`=0.
  - It clears on any pop and in IDLE.
  - When it reaches `TIMEOUT`, the burst is abandoned: go to IDLE, `rem`←0, and `err_o`=1 and `done_o`=1 together in the next cycle.
  - The truncated burst carries no `m_last_o`. A word still in the output register is never subject to timeout.
- **Undefined:** no counter and no `TIMEOUT` logic; `err_o` is tied to 0; RUN waits on the FIFO indefinitely.

## Structure
- Shared package `fifo_stream_reader_pkg` holds:
  - the state enum typedef (IDLE, RUN);
  - the default constants for `WIDTH`, `LEN_WIDTH` and `TIMEOUT`.
- Single module with no sub-module. The FIFO is instantiated by the parent; the output register is a few lines and stays inline.

## Test plan
- **Basic burst:** FIFO preloaded with 0x10..0x13, `len_i`=4, `m_ready_i`=1 → data 0x10,0x11,0x12,0x13 on consecutive cycles 2..5, `m_last_o` only with 0x13, `done_o` in cycle 6, 4 pops total.
- **Backpressure:** same burst with `m_ready_i` toggling 1,0,0,1,… → no data loss or duplication, output held stable during stalls, exactly 4 pops.
- **Starved FIFO:** empty FIFO, `len_i`=3, writes trickle in every 3rd cycle → no pop while `fifo_empty_i`=1, 3 words delivered, `done_o` after the third handshake.
- **Boundary lengths and ignored start:**
  - `len_i`=0 → `done_o` pulse with no pop and no `m_valid_o`.
  - `len_i`=255 with 300 words queued → exactly 255 popped and 45 remain.
  - `start_i` pulsed during RUN → ignored.
- **Reset mid-burst:** `rst_i` asserted with `m_valid_o`=1 → next cycle all outputs 0 and IDLE; a fresh `len_i`=2 burst works.
- **Timeout (macro on, `TIMEOUT`=4):** `len_i`=2, one word available → word delivered, then after 4 starved cycles `err_o`=1 and `done_o`=1 with `m_last_o` never asserted.
